// File: rtl/jtag_master_shift.sv
// JTAG master shifter: clocks up to MAX_LEN TMS/TDI bits out LSB-first and captures TDO per bit.
// Define JTAG_MASTER_RESET_SEQ_EN to issue five TMS=1 TCK pulses after reset release.
module jtag_master_shift #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 32
) (
  input  logic        clk_8388,
  input  logic        ck_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_len,
  input  logic [31:0] cmd_tms,
  input  logic [31:0] cmd_tdi,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_tdo,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
`ifdef JTAG_MASTER_RESET_SEQ_EN
    , S_RSTSEQ
`endif
  } state_t;

`ifdef JTAG_MASTER_RESET_SEQ_EN
  localparam state_t RST_STATE = S_RSTSEQ;
`else
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t      state;
  state_t      state_nx;
  logic [7:0]  div_cnt;
  logic        div_last;
  logic [5:0]  bit_idx;
  logic [5:0]  len_q;
  logic [5:0]  len_clamp;
  logic        last_bit;
  logic [31:0] tms_sh;
  logic [31:0] tdi_sh;
  logic        tdo_s1;
  logic        tdo_s2;
`ifdef JTAG_MASTER_RESET_SEQ_EN
  logic        rs_high;
`endif

  assign div_last  = (div_cnt == 8'(CLK_DIV - 1));
  assign len_clamp = (cmd_len > 6'(MAX_LEN)) ? 6'(MAX_LEN) : cmd_len;
  assign last_bit  = (bit_idx == len_q - 6'd1);

  always_ff @(posedge clk_8388 or negedge ck_rst) begin
    if (!ck_rst) state <= RST_STATE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) state_nx = (len_clamp == 6'd0) ? S_DONE : S_LOW;
      end
      S_LOW: begin
        if (div_last) state_nx = S_HIGH;
      end
      S_HIGH: begin
        if (div_last) state_nx = last_bit ? S_DONE : S_LOW;
      end
      S_DONE: begin
        if (rsp_ready) state_nx = S_IDLE;
      end
`ifdef JTAG_MASTER_RESET_SEQ_EN
      S_RSTSEQ: begin
        if (div_last && rs_high && bit_idx == 6'd4) state_nx = S_IDLE;
      end
`endif
      default: state_nx = RST_STATE;
    endcase
  end

  // Handshake outputs are gated by ck_rst so they drop the instant reset asserts.
  always_comb begin
    cmd_ready = ck_rst && (state == S_IDLE);
    busy      = ck_rst && (state != S_IDLE);
    rsp_valid = (state == S_DONE);
`ifdef JTAG_MASTER_RESET_SEQ_EN
    tck       = (state == S_HIGH) || ((state == S_RSTSEQ) && rs_high);
`else
    tck       = (state == S_HIGH);
`endif
  end

  always_ff @(posedge clk_8388 or negedge ck_rst) begin
    if (!ck_rst) begin
      div_cnt <= '0;
      bit_idx <= '0;
      len_q   <= '0;
      tms_sh  <= '0;
      tdi_sh  <= '0;
      rsp_tdo <= '0;
      tms     <= 1'b1;
      tdi     <= 1'b0;
      tdo_s1  <= 1'b0;
      tdo_s2  <= 1'b0;
`ifdef JTAG_MASTER_RESET_SEQ_EN
      rs_high <= 1'b0;
`endif
    end else begin
      tdo_s1 <= tdo;
      tdo_s2 <= tdo_s1;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            len_q   <= len_clamp;
            tms_sh  <= cmd_tms >> 1;
            tdi_sh  <= cmd_tdi >> 1;
            rsp_tdo <= '0;
            div_cnt <= '0;
            bit_idx <= '0;
            // A zero-length command leaves the pins at the previous command's last bit.
            if (len_clamp != 6'd0) begin
              tms <= cmd_tms[0];
              tdi <= cmd_tdi[0];
            end
          end
        end
        S_LOW: begin
          div_cnt <= div_last ? 8'd0 : div_cnt + 8'd1;
        end
        S_HIGH: begin
          div_cnt <= div_last ? 8'd0 : div_cnt + 8'd1;
          if (div_last) begin
            rsp_tdo[bit_idx[4:0]] <= tdo_s2;
            bit_idx <= bit_idx + 6'd1;
            if (!last_bit) begin
              tms    <= tms_sh[0];
              tdi    <= tdi_sh[0];
              tms_sh <= tms_sh >> 1;
              tdi_sh <= tdi_sh >> 1;
            end
          end
        end
`ifdef JTAG_MASTER_RESET_SEQ_EN
        S_RSTSEQ: begin
          div_cnt <= div_last ? 8'd0 : div_cnt + 8'd1;
          if (div_last) begin
            rs_high <= !rs_high;
            if (rs_high) bit_idx <= bit_idx + 6'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_master_shift.sv
// Directed bench for jtag_master_shift (CLK_DIV=4) with a shift-out TAP model on tdo.
module tb_jtag_master_shift;

  logic        clk_8388 = 1'b0;
  logic        ck_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_tms;
  logic [31:0] cmd_tdi;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_tdo;
  logic        tck;
  logic        tms;
  logic        tdi;
  logic        tdo;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int pos_cnt  = 0;
  int neg_cnt  = 0;
  int base_pos = 0;
  int base_neg = 0;
  int rsp_cyc;
  int hi_cnt;
  logic [31:0] tap_data = '0;
  logic [31:0] cap_tms  = '0;
  logic [31:0] cap_tdi  = '0;

  jtag_master_shift #(.CLK_DIV(4), .MAX_LEN(32)) dut (
    .clk_8388  (clk_8388),
    .ck_rst    (ck_rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_tms   (cmd_tms),
    .cmd_tdi   (cmd_tdi),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_tdo   (rsp_tdo),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .busy      (busy)
  );

  always #5 clk_8388 = ~clk_8388;

  // TAP model: bit k of tap_data is presented after the k-th falling tck of the command.
  assign tdo = tap_data[5'(neg_cnt - base_neg)];

  always @(negedge tck) neg_cnt <= neg_cnt + 1;

  always @(posedge tck) begin
    pos_cnt <= pos_cnt + 1;
    cap_tms <= {tms, cap_tms[31:1]};
    cap_tdi <= {tdi, cap_tdi[31:1]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [5:0] len, input logic [31:0] tmsv, input logic [31:0] tdiv);
    @(negedge clk_8388);
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    base_pos  = pos_cnt;
    base_neg  = neg_cnt;
    cmd_len   = len;
    cmd_tms   = tmsv;
    cmd_tdi   = tdiv;
    cmd_valid = 1'b1;
    @(posedge clk_8388);
    #1;
    cmd_valid = 1'b0;
    cmd_tms   = ~tmsv;
    cmd_tdi   = ~tdiv;
    cmd_len   = ~len;
  endtask

  // Called at #1 after edge `start`; returns the cycle in which rsp_valid is first seen.
  task automatic wait_rsp(input int start);
    rsp_cyc = start;
    hi_cnt  = 0;
    while (!rsp_valid && rsp_cyc < 600) begin
      if (tck) hi_cnt++;
      @(posedge clk_8388);
      #1;
      rsp_cyc++;
    end
  endtask

  task automatic release_rsp();
    @(negedge clk_8388);
    rsp_ready = 1'b1;
    @(posedge clk_8388);
    #1;
    check("idle_ready_after_rsp", 32'(cmd_ready), 32'd1);
    check("rsp_valid_dropped", 32'(rsp_valid), 32'd0);
    @(negedge clk_8388);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int bad;
    int k;
    logic [31:0] hold;
    ck_rst    = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_tms   = '0;
    cmd_tdi   = '0;
    rsp_ready = 1'b0;
    #12;
    check("rst_tck", 32'(tck), 32'd0);
    check("rst_tms", 32'(tms), 32'd1);
    check("rst_tdi", 32'(tdi), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_tdo", rsp_tdo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    @(negedge clk_8388);
    base_pos = pos_cnt;
    ck_rst   = 1'b1;
    #1;
`ifdef JTAG_MASTER_RESET_SEQ_EN
    check("rstseq_busy", 32'(busy), 32'd1);
    bad = (cmd_ready !== 1'b0) ? 1 : 0;
    for (int i = 1; i < 40; i++) begin
      @(posedge clk_8388);
      #1;
      if (cmd_ready !== 1'b0) bad++;
    end
    check("rstseq_ready_low_40", 32'(bad), 32'd0);
    @(posedge clk_8388);
    #1;
    check("rstseq_ready_after", 32'(cmd_ready), 32'd1);
    check("rstseq_pulses", 32'(pos_cnt - base_pos), 32'd5);
    check("rstseq_tms", cap_tms >> 27, 32'h1F);
`else
    check("ready_after_release", 32'(cmd_ready), 32'd1);
    check("busy_after_release", 32'(busy), 32'd0);
`endif

    // len=5, tms all ones, zero TDO
    tap_data = 32'h0;
    send(6'd5, 32'h1F, 32'h0);
    wait_rsp(1);
    check("a_rsp_cycle", 32'(rsp_cyc), 32'd41);
    check("a_pulses", 32'(pos_cnt - base_pos), 32'd5);
    check("a_high_cycles", 32'(hi_cnt), 32'd20);
    check("a_tms_bits", cap_tms >> 27, 32'h1F);
    check("a_rsp_tdo", rsp_tdo, 32'h0);
    check("a_tms_hold", 32'(tms), 32'd1);
    hold = rsp_tdo;
    bad  = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_8388);
      #1;
      if (!rsp_valid || rsp_tdo !== hold || cmd_ready || tck) bad++;
    end
    check("a_hold_stable", 32'(bad), 32'd0);
    release_rsp();

    // len=32 against the shifting TAP model
    tap_data = 32'h1E200A6D;
    send(6'd32, 32'h0, 32'hA5A5A5A5);
    wait_rsp(1);
    check("b_rsp_cycle", 32'(rsp_cyc), 32'd257);
    check("b_rsp_tdo", rsp_tdo, 32'h1E200A6D);
    check("b_tdi_bits", cap_tdi, 32'hA5A5A5A5);
    check("b_tdi_hold", 32'(tdi), 32'd1);
    check("b_tms_hold", 32'(tms), 32'd0);
    release_rsp();

    // len=0: immediate response, no tck
    send(6'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_rsp(1);
    check("c_rsp_cycle", 32'(rsp_cyc), 32'd1);
    check("c_rsp_tdo", rsp_tdo, 32'h0);
    check("c_pulses", 32'(pos_cnt - base_pos), 32'd0);
    check("c_tms_hold", 32'(tms), 32'd0);
    release_rsp();

    // len=40 clamps to 32
    tap_data = 32'hDEADBEEF;
    send(6'd40, 32'h0, 32'h0);
    wait_rsp(1);
    check("d_rsp_cycle", 32'(rsp_cyc), 32'd257);
    check("d_pulses", 32'(pos_cnt - base_pos), 32'd32);
    check("d_rsp_tdo", rsp_tdo, 32'hDEADBEEF);
    release_rsp();

    // len=8 with command inputs toggled during the shift; upper response bits stay 0
    tap_data = 32'hFFFFFFFF;
    send(6'd8, 32'h5A, 32'h3C);
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_8388);
      #1;
    end
    cmd_valid = 1'b0;
    wait_rsp(4);
    check("e_rsp_cycle", 32'(rsp_cyc), 32'd65);
    check("e_pulses", 32'(pos_cnt - base_pos), 32'd8);
    check("e_rsp_tdo", rsp_tdo, 32'h000000FF);
    check("e_tms_bits", cap_tms >> 24, 32'h5A);
    check("e_tdi_bits", cap_tdi >> 24, 32'h3C);
    release_rsp();

    // reset asserted during the HIGH phase of bit 3
    tap_data = 32'h0;
    send(6'd8, 32'h0, 32'hFF);
    k = 0;
    while (!((pos_cnt - base_pos) == 4 && tck) && k < 200) begin
      @(posedge clk_8388);
      #1;
      k++;
    end
    check("f_reach_bit3_high", 32'(k < 200), 32'd1);
    check("f_tms_before_rst", 32'(tms), 32'd0);
    #2;
    ck_rst = 1'b0;
    #1;
    check("f_rst_tck", 32'(tck), 32'd0);
    check("f_rst_tms", 32'(tms), 32'd1);
    check("f_rst_busy", 32'(busy), 32'd0);
    check("f_rst_rsp_tdo", rsp_tdo, 32'h0);
    @(negedge clk_8388);
    ck_rst = 1'b1;
    #1;
`ifndef JTAG_MASTER_RESET_SEQ_EN
    check("f_ready_after_release", 32'(cmd_ready), 32'd1);
`endif
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk_8388);
      #1;
      if (rsp_valid) bad++;
    end
    check("f_no_rsp_after_rst", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
